// File: rtl/divisor_arbiter.sv
// divisor_arbiter: shares one iterative divider among N_REQ requesters.
// Round-robin grant, operand latch, Start/Done sequencing, local divide-by-zero
// handling and a watchdog that aborts a division that never finishes.
module divisor_arbiter #(
  parameter int N_REQ   = 4,
  parameter int SIZE    = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                  CLK,
  input  logic                  RSTa,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ*SIZE-1:0] num_in,
  input  logic [N_REQ*SIZE-1:0] den_in,
  output logic [N_REQ-1:0]      ack,
  output logic [SIZE-1:0]       coc_out,
  output logic [SIZE-1:0]       res_out,
  output logic                  err_out,
  output logic                  busy,
  output logic                  div_start,
  output logic [SIZE-1:0]       div_num,
  output logic [SIZE-1:0]       div_den,
  input  logic [SIZE-1:0]       div_coc,
  input  logic [SIZE-1:0]       div_res,
  input  logic                  div_done
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  // Packed per-requester views of the flat operand buses.
  logic [N_REQ-1:0][SIZE-1:0] num_a, den_a;
  assign num_a = num_in;
  assign den_a = den_in;

  logic [1:0]      state;
  logic [IW-1:0]   rr_ptr, idx, win;
  logic [SIZE-1:0] num_r, den_r;
  logic [WW-1:0]   wdog;
  int              j;

  // Winner: first requester set, scanning upward from rr_ptr with wrap.
  always_comb begin
    win = '0;
    j   = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = int'(rr_ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (req[j]) win = IW'(j);
    end
  end

  // Arbiter FSM; results and error flag are registered at the edge into RESP.
  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      state   <= S_IDLE;
      rr_ptr  <= '0;
      idx     <= '0;
      num_r   <= '0;
      den_r   <= '0;
      wdog    <= '0;
      coc_out <= '0;
      res_out <= '0;
      err_out <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (|req) begin
          idx   <= win;
          num_r <= num_a[win];
          den_r <= den_a[win];
          if (den_a[win] == '0) begin
            // Divide-by-zero never reaches the divider.
            coc_out <= '1;
            res_out <= num_a[win];
            err_out <= 1'b1;
            state   <= S_RESP;
          end else begin
            state <= S_START;
          end
        end
        S_START: begin
          wdog  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (div_done) begin
            coc_out <= div_coc;
            res_out <= div_res;
            err_out <= 1'b0;
            state   <= S_RESP;
          end else if (wdog == WW'(TIMEOUT - 1)) begin
            // Hung divider: report an error with zeroed results.
            coc_out <= '0;
            res_out <= '0;
            err_out <= 1'b1;
            state   <= S_RESP;
          end else begin
            wdog <= wdog + WW'(1);
          end
        end
        default: begin
          rr_ptr <= (idx == IW'(N_REQ - 1)) ? '0 : idx + IW'(1);
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign div_start = (state == S_START);
  assign div_num   = num_r;
  assign div_den   = den_r;

  // One-hot completion pulse decoded from state and the latched winner.
  for (genvar g = 0; g < N_REQ; g++) begin : g_ack
    assign ack[g] = (state == S_RESP) && (idx == IW'(g));
  end

endmodule
